// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute control and register file for the 4-bit ALU.
// Instructions are {op[3:0], im[3:0]}. The ALU result and carry are written back at the edge that ends EXEC.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] alu_ain,
  output logic [3:0] alu_bin,
  input  logic [3:0] alu_out,
  input  logic       alu_c,
  output logic [3:0] out_port,
  output logic [3:0] pc
);

  localparam int unsigned DW = 4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          cf_q, cf_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] ain_c, bin_c;
  logic [DW-1:0] op_c, im_c;

  assign op_c = rom_data[7:4];
  assign im_c = rom_data[3:0];

  // State and register file update; reset overrides any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      a_q     <= '0;
      b_q     <= '0;
      cf_q    <= 1'b0;
      pc_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cf_q    <= cf_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Next-state decode: operand selection and destination write from the ALU result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cf_d    = cf_q;
    pc_d    = pc_q;
    out_d   = out_q;
    ain_c   = '0;
    bin_c   = '0;
    unique case (state_q)
      ST_FETCH: begin
        if (run) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        cf_d    = alu_c;
        pc_d    = pc_q + DW'(1);
        case (op_c)
          4'h0: begin ain_c = a_q;     bin_c = im_c; a_d   = alu_out; end
          4'h5: begin ain_c = b_q;     bin_c = im_c; b_d   = alu_out; end
          4'h3: begin                  bin_c = im_c; a_d   = alu_out; end
          4'h7: begin                  bin_c = im_c; b_d   = alu_out; end
          4'h1: begin ain_c = b_q;                   a_d   = alu_out; end
          4'h4: begin ain_c = a_q;                   b_d   = alu_out; end
          4'h2: begin ain_c = in_port;               a_d   = alu_out; end
          4'h6: begin ain_c = in_port;               b_d   = alu_out; end
          4'h9: begin ain_c = b_q;                   out_d = alu_out; end
          4'hB: begin                  bin_c = im_c; out_d = alu_out; end
          4'hF: begin                  bin_c = im_c; pc_d  = alu_out; end
          4'hE: begin
            bin_c = im_c;
            if (!cf_q) pc_d = alu_out;
          end
          default: ;
        endcase
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign alu_ain  = ain_c;
  assign alu_bin  = bin_c;
  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign out_port = out_q;

endmodule
